// File: rtl/multi_dataflow_job_sched.sv
// Job scheduler for the multi_dataflow cipher datapath: issues credit-limited block
// requests and retires blocks by counting chiped_text beats. Optional watchdog: MULTI_DATAFLOW_SCHED_WDOG_EN.
module multi_dataflow_job_sched #(
   parameter int N_BLOCKS_W      = 16,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int MAX_INFLIGHT    = 2,
   parameter int WDOG_CYCLES     = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  start_i,
   input  logic [N_BLOCKS_W-1:0] n_blocks_i,
   output logic                  src_req_valid_o,
   input  logic                  src_req_ready_i,
   input  logic                  out_valid_i,
   input  logic                  out_ready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  evt_o,
   output logic [N_BLOCKS_W-1:0] blocks_done_o,
   output logic                  err_o,
   output logic                  timeout_o
);

   localparam int IF_W   = $clog2(MAX_INFLIGHT + 1);
   localparam int BEAT_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS_PER_BLOCK - 1);
   localparam logic [IF_W-1:0]   MAX_IF    = IF_W'(MAX_INFLIGHT);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                  state_reg;
   logic [N_BLOCKS_W-1:0]   n_reg;
   logic [N_BLOCKS_W-1:0]   issued_reg;
   logic [N_BLOCKS_W-1:0]   completed_reg;
   logic [IF_W-1:0]         inflight_reg;
   logic [BEAT_W-1:0]       beat_reg;
   logic                    valid_reg;
   logic                    busy_reg;
   logic                    done_reg;
   logic                    err_reg;

   logic                    active;
   logic                    fire;
   logic                    beat;
   logic                    beat_ok;
   logic                    retire;
   logic                    wdog_hit;
   logic [N_BLOCKS_W-1:0]   issued_next;
   logic [N_BLOCKS_W-1:0]   completed_next;
   logic [IF_W-1:0]         inflight_next;
   logic [BEAT_W-1:0]       beat_next;

   // A beat only counts while a job is running and some block is outstanding.
   always_comb begin
      active         = (state_reg == ISSUE) || (state_reg == DRAIN);
      fire           = valid_reg & src_req_ready_i;
      beat           = out_valid_i & out_ready_i;
      beat_ok        = beat & active & (inflight_reg != '0);
      retire         = beat_ok & (beat_reg == BEAT_LAST);
      issued_next    = issued_reg + N_BLOCKS_W'(fire);
      completed_next = completed_reg + N_BLOCKS_W'(retire);
      inflight_next  = inflight_reg;
      if (fire && !retire) begin
         inflight_next = inflight_reg + IF_W'(1);
      end else if (!fire && retire) begin
         inflight_next = inflight_reg - IF_W'(1);
      end
      beat_next = beat_reg;
      if (retire) begin
         beat_next = '0;
      end else if (beat_ok) begin
         beat_next = beat_reg + BEAT_W'(1);
      end
   end

`ifdef MULTI_DATAFLOW_SCHED_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

   logic [WDOG_W-1:0] stall_reg;
   logic              timeout_reg;

   always_comb begin
      wdog_hit = active & ~fire & ~beat_ok & (stall_reg == WDOG_W'(WDOG_CYCLES - 1));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         stall_reg   <= '0;
         timeout_reg <= 1'b0;
      end else begin
         if (!active || fire || beat_ok) begin
            stall_reg <= '0;
         end else begin
            stall_reg <= stall_reg + WDOG_W'(1);
         end
         if (wdog_hit) begin
            timeout_reg <= 1'b1;
         end
      end
   end

   assign timeout_o = timeout_reg;
`else
   always_comb begin
      wdog_hit = 1'b0;
   end

   assign timeout_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_reg     <= IDLE;
         n_reg         <= '0;
         issued_reg    <= '0;
         completed_reg <= '0;
         inflight_reg  <= '0;
         beat_reg      <= '0;
         valid_reg     <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         done_reg      <= 1'b0;
         issued_reg    <= issued_next;
         completed_reg <= completed_next;
         inflight_reg  <= inflight_next;
         beat_reg      <= beat_next;
         if (beat && !beat_ok) begin
            err_reg <= 1'b1;
         end
         case (state_reg)
            IDLE: begin
               if (start_i) begin
                  n_reg         <= n_blocks_i;
                  issued_reg    <= '0;
                  completed_reg <= '0;
                  inflight_reg  <= '0;
                  beat_reg      <= '0;
                  if (n_blocks_i != '0) begin
                     state_reg <= ISSUE;
                     busy_reg  <= 1'b1;
                     valid_reg <= 1'b1;
                  end else begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (wdog_hit) begin
                  state_reg <= DONE;
                  busy_reg  <= 1'b0;
                  valid_reg <= 1'b0;
                  done_reg  <= 1'b1;
               end else if (issued_next == n_reg) begin
                  state_reg <= DRAIN;
                  valid_reg <= 1'b0;
               end else begin
                  // Looks at next-cycle credit so a retire re-opens the request at once.
                  valid_reg <= (inflight_next < MAX_IF);
               end
            end
            DRAIN: begin
               if (wdog_hit || (completed_reg == n_reg)) begin
                  state_reg <= DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign src_req_valid_o = valid_reg;
   assign busy_o          = busy_reg;
   assign done_o          = done_reg;
   assign evt_o           = done_reg;
   assign blocks_done_o   = completed_reg;
   assign err_o           = err_reg;

endmodule
